// File: rtl/circuit_pkg.sv
// rtl/circuit_pkg.sv - shared constants for the Fibonacci sequence generator
//
// Purpose : default width and reset values shared by circuit and its sub-module.
// Ports   : none (package).
package circuit_pkg;

  localparam int CIRCUIT_W_DEFAULT = 96;

  // Reset state: y holds F(0), b holds F(1).
  localparam int Y_RST = 0;
  localparam int B_RST = 1;

endpackage

// File: rtl/circuit_en_reg.sv
// rtl/circuit_en_reg.sv - W-bit enabled register with async active-low reset
//
// Purpose : storage element used for y, b and the optional sticky overflow bit.
// Ports   : clk     - clock, rising edge
//           rst     - asynchronous active-low reset, loads RST_VAL
//           i_en    - load enable
//           i_d     - next value
//           o_q     - registered value
module circuit_en_reg #(
  parameter int           W       = 96,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= RST_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/circuit.sv
// rtl/circuit.sv - free-running Fibonacci sequence generator, modulo 2^W
//
// Purpose : each enabled edge advances y to the next Fibonacci term.
//           Optional macro CIRCUIT_OVF_EN adds a sticky carry-out flag.
// Ports   : clk  - clock, rising edge
//           rst  - asynchronous active-low reset (y=0, b=1, ovf=0)
//           en   - advance enable
//           y    - current term F(n), registered
//           ovf  - sticky overflow flag (only with CIRCUIT_OVF_EN)
module circuit
  import circuit_pkg::*;
#(
  parameter int W = CIRCUIT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] y
`ifdef CIRCUIT_OVF_EN
  ,
  output logic         ovf
`endif
);

  logic [W-1:0] w_y;
  logic [W-1:0] w_b;
  logic [W-1:0] w_sum;

`ifdef CIRCUIT_OVF_EN
  logic [W:0] w_sum_full;
  logic       w_carry;
  logic [0:0] w_ovf;

  // One extra bit only to observe the carry; the stored term still wraps.
  assign w_sum_full = {1'b0, w_y} + {1'b0, w_b};
  assign w_sum      = w_sum_full[W-1:0];
  assign w_carry    = w_sum_full[W];

  // Sticky: only ever loads a 1, cleared solely by reset.
  circuit_en_reg #(
    .W       (1),
    .RST_VAL (1'b0)
  ) u_ovf_reg (
    .clk  (clk),
    .rst  (rst),
    .i_en (en & w_carry),
    .i_d  (1'b1),
    .o_q  (w_ovf)
  );

  assign ovf = w_ovf[0];
`else
  assign w_sum = w_y + w_b;
`endif

  circuit_en_reg #(
    .W       (W),
    .RST_VAL (W'(Y_RST))
  ) u_y_reg (
    .clk  (clk),
    .rst  (rst),
    .i_en (en),
    .i_d  (w_b),
    .o_q  (w_y)
  );

  circuit_en_reg #(
    .W       (W),
    .RST_VAL (W'(B_RST))
  ) u_b_reg (
    .clk  (clk),
    .rst  (rst),
    .i_en (en),
    .i_d  (w_sum),
    .o_q  (w_b)
  );

  assign y = w_y;

endmodule

// File: tb/tb_circuit.sv
// tb/tb_circuit.sv - self-checking bench for circuit at W=96 and W=8
module tb_circuit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [95:0] y96;
  logic [7:0]  y8;
`ifdef CIRCUIT_OVF_EN
  logic        ovf96;
  logic        ovf8;
`endif

  int checks   = 0;
  int failures = 0;
  int k        = 0;  // enabled edges since the last reset (shared by both DUTs)

  always #5 clk = ~clk;

  circuit #(.W(96)) u_dut96 (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .y   (y96)
`ifdef CIRCUIT_OVF_EN
    ,
    .ovf (ovf96)
`endif
  );

  circuit #(.W(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .y   (y8)
`ifdef CIRCUIT_OVF_EN
    ,
    .ovf (ovf8)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // F(k) mod 2^w, computed from the recurrence on term indices.
  function automatic logic [127:0] fib_mod(input int kk, input int w);
    logic [127:0] m, a, b, t;
    m = (128'd1 << w) - 128'd1;
    a = 128'd0;
    b = 128'd1;
    for (int i = 0; i < kk; i++) begin
      t = (a + b) & m;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // True if any of the first kk additions of wrapped terms exceeded 2^w.
  function automatic logic carry_seen(input int kk, input int w);
    logic [127:0] m, a, b, s;
    logic c;
    m = (128'd1 << w) - 128'd1;
    a = 128'd0;
    b = 128'd1;
    c = 1'b0;
    for (int i = 0; i < kk; i++) begin
      s = a + b;
      if ((s >> w) != 128'd0) c = 1'b1;
      a = b;
      b = s & m;
    end
    return c;
  endfunction

  task automatic compare_model(input string tag);
    check({tag, "_y96"}, {32'd0, y96}, fib_mod(k, 96));
    check({tag, "_y8"}, {120'd0, y8}, fib_mod(k, 8));
`ifdef CIRCUIT_OVF_EN
    check({tag, "_ovf96"}, {127'd0, ovf96}, {127'd0, carry_seen(k, 96)});
    check({tag, "_ovf8"}, {127'd0, ovf8}, {127'd0, carry_seen(k, 8)});
`endif
  endtask

  // One clock edge with the given enable; sample 1 time unit after the edge.
  task automatic cycle(input logic e, input string tag);
    en = e;
    @(posedge clk);
    #1;
    if (e) k++;
    compare_model(tag);
  endtask

  // Reset pulse placed between edges; y must clear before the next edge.
  task automatic reset_pulse(input string tag);
    #2;
    rst = 1'b0;
    #1;
    k = 0;
    check({tag, "_async_y96"}, {32'd0, y96}, 128'd0);
    check({tag, "_async_y8"}, {120'd0, y8}, 128'd0);
`ifdef CIRCUIT_OVF_EN
    check({tag, "_async_ovf8"}, {127'd0, ovf8}, 128'd0);
`endif
    #1;
    rst = 1'b1;
  endtask

  initial begin
    // Reset held with en toggling: state must not move.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      en = i[0];
      @(posedge clk);
      #1;
    end
    check("rst_y96", {32'd0, y96}, 128'd0);
    check("rst_y8", {120'd0, y8}, 128'd0);
`ifdef CIRCUIT_OVF_EN
    check("rst_ovf8", {127'd0, ovf8}, 128'd0);
`endif
    en  = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1'b0, "idle");

    // Basic sequence and hold.
    cycle(1'b1, "seq");
    check("k1", {32'd0, y96}, 128'd1);
    cycle(1'b1, "seq");
    check("k2", {32'd0, y96}, 128'd1);
    cycle(1'b1, "seq");
    check("k3", {32'd0, y96}, 128'd2);
    while (k < 10) cycle(1'b1, "seq");
    check("k10", {32'd0, y96}, 128'd55);
    for (int i = 0; i < 7; i++) cycle(1'b0, "hold");
    check("hold55", {32'd0, y96}, 128'd55);
    cycle(1'b1, "seq");
    check("k11", {32'd0, y96}, 128'd89);

    // W=8 wrap and overflow around edges 12..15.
    cycle(1'b1, "seq");
`ifdef CIRCUIT_OVF_EN
    check("ovf_k12", {127'd0, ovf8}, 128'd0);
`endif
    cycle(1'b1, "seq");
    check("w8_k13", {120'd0, y8}, 128'd233);
`ifdef CIRCUIT_OVF_EN
    check("ovf_k13", {127'd0, ovf8}, 128'd1);
`endif
    cycle(1'b1, "seq");
    check("w8_k14", {120'd0, y8}, 128'd121);
    cycle(1'b1, "seq");
    check("w8_k15", {120'd0, y8}, 128'd98);
    for (int i = 0; i < 4; i++) cycle(i[0], "sticky");
`ifdef CIRCUIT_OVF_EN
    check("ovf_sticky", {127'd0, ovf8}, 128'd1);
`endif

    // Mid-run reset at y=144.
    reset_pulse("r0");
    while (k < 12) cycle(1'b1, "seq");
    check("k12", {32'd0, y96}, 128'd144);
    reset_pulse("r1");
    cycle(1'b1, "post");
    check("post1", {32'd0, y96}, 128'd1);
    cycle(1'b1, "post");
    check("post2", {32'd0, y96}, 128'd1);

    // Long run to F(100).
    while (k < 100) cycle(1'b1, "long");
    check("k100", {32'd0, y96}, 128'd354224848179261915075);

    // Randomized enable and occasional mid-cycle resets.
    reset_pulse("r2");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) reset_pulse("rnd_rst");
      cycle(($urandom_range(0, 3) != 0), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
